uart_rx: RTL and testbench

//  Receive-side partner of the send_alphabet/uart TX path: samples ftdi_rxd (8N1, LSB first),

---
 rtl/uart_pkg.sv | 39 +++
 rtl/uart_baud_tick.sv | 47 ++++
 rtl/uart_rx.sv | 214 +++++++++++++++++++++
 tb/tb_uart_rx.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the RX and TX paths: receiver state encoding,
// data width and the baud tick increment helper.
// Optional build macro: UART_RX_PARITY_EN selects 8E1 framing, which adds the
// PARITY state to the receiver.
package uart_pkg;

    localparam int unsigned UART_DATA_W = 8;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;
`endif

    // Phase accumulator increment for a tick rate of baud*os; the result is
    // capped at one tick per clock.
    function automatic int unsigned baud_inc(input int unsigned clk,
                                             input int unsigned baud,
                                             input int unsigned os);
        int unsigned inc;
        inc = baud * os;
        if (inc > clk) begin
            inc = clk;
        end
        return inc;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Drift-free fractional tick generator. A phase accumulator adds RATE on every
// clock and wraps at CLK_FREQ, so the average tick rate is exactly RATE Hz.
module uart_baud_tick #(
    parameter int unsigned CLK_FREQ = 25_000_000,
    parameter int unsigned RATE     = 1_843_200
) (
    input  logic clk_25mhz,
    input  logic reset,
    output logic tick
);

    // One spare bit keeps acc + RATE from overflowing before the wrap compare.
    localparam int unsigned ACC_W = $clog2(CLK_FREQ + RATE) + 1;
    localparam logic [ACC_W-1:0] ACC_INC = ACC_W'(RATE);
    localparam logic [ACC_W-1:0] ACC_LIM = ACC_W'(CLK_FREQ);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] acc_sum;
    logic             tick_q;
    logic             tick_d;

    // Advance the phase and flag a tick when it wraps.
    always_comb begin
        acc_sum = acc_q + ACC_INC;
        acc_d   = acc_sum;
        tick_d  = 1'b0;
        if (acc_sum >= ACC_LIM) begin
            acc_d  = acc_sum - ACC_LIM;
            tick_d = 1'b1;
        end
    end

    // Accumulator and tick registers.
    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            acc_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-FF input synchronizer, oversampling frame FSM, LSB-first
// shift register and a valid/ready output holding register.
// Optional build macro: UART_RX_PARITY_EN adds an even parity bit (8E1) and
// the parity_err pulse output.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 25_000_000,
    parameter int unsigned BAUD       = 115_200,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                   clk_25mhz,
    input  logic                   reset,
    input  logic                   ftdi_rxd,
    output logic [UART_DATA_W-1:0] rx_data,
    output logic                   rx_valid,
    input  logic                   rx_ready,
    output logic                   frame_err,
    output logic                   overrun
`ifdef UART_RX_PARITY_EN
    ,
    output logic                   parity_err
`endif
);

    localparam int unsigned W      = UART_DATA_W;
    localparam int unsigned CNT_W  = $clog2(OVERSAMPLE);
    localparam int unsigned IDX_W  = $clog2(W);
    localparam int unsigned RATE   = baud_inc(CLK_FREQ, BAUD, OVERSAMPLE);

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(W - 1);

    logic tick;

    logic             rxd_meta_q, rxd_meta_d;
    logic             rxd_sync_q, rxd_sync_d;
    rx_state_t        state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [IDX_W-1:0] idx_q,      idx_d;
    logic [W-1:0]     shift_q,    shift_d;
    logic [W-1:0]     rx_data_q,  rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q,  overrun_d;
    logic             byte_done;
`ifdef UART_RX_PARITY_EN
    logic             parity_bad_q, parity_bad_d;
    logic             parity_err_q, parity_err_d;
`endif

    // Oversampling tick source shared with the transmitter.
    uart_baud_tick #(
        .CLK_FREQ (CLK_FREQ),
        .RATE     (RATE)
    ) u_baud_tick (
        .clk_25mhz (clk_25mhz),
        .reset     (reset),
        .tick      (tick)
    );

    // Next-state logic: synchronizer, frame FSM and output holding register.
    always_comb begin
        rxd_meta_d  = ftdi_rxd;
        rxd_sync_d  = rxd_meta_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = 1'b0;
        overrun_d   = overrun_q;
        byte_done   = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bad_d = parity_bad_q;
        parity_err_d = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                if (!rxd_sync_q) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                // Mid-start re-check rejects glitches shorter than half a bit.
                if (tick) begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_d = '0;
                        idx_d = '0;
                        state_d = rxd_sync_q ? IDLE : DATA;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        shift_d = {rxd_sync_q, shift_q[W-1:1]};
                        if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                // Even parity: data bits XOR parity bit must be zero.
                if (tick) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d        = '0;
                        parity_bad_d = (^shift_q) ^ rxd_sync_q;
                        state_d      = STOP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                        if (!rxd_sync_q) begin
                            frame_err_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if (parity_bad_q) begin
                            parity_err_d = 1'b1;
`endif
                        end else begin
                            byte_done = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A completing byte replaces the held one only if the consumer takes
        // the held one on the same edge; otherwise it is dropped as overrun.
        if (byte_done) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = shift_d;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    // State and output registers; reset aborts any frame in progress.
    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            rxd_meta_q  <= 1'b1;
            rxd_sync_q  <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad_q <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rxd_meta_q  <= rxd_meta_d;
            rxd_sync_q  <= rxd_sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
            parity_bad_q <= parity_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed and random serial frames driven into uart_rx at 217 clocks per bit;
// delivered bytes are collected from the valid/ready handshake and compared
// against the bytes the bench expects from each frame.
module tb_uart_rx;

    localparam int unsigned BIT = 217;

    logic       clk_25mhz = 1'b0;
    logic       reset     = 1'b1;
    logic       ftdi_rxd  = 1'b1;
    logic       rx_ready  = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
    int         pe_cycles = 0;
`endif

    int         checks = 0;
    int         fails  = 0;
    int         valid_cycles = 0;
    int         fe_cycles    = 0;
    logic [7:0] deliv_q[$];
    logic [7:0] exp_q[$];

    always #20 clk_25mhz = ~clk_25mhz;

    uart_rx dut (
        .clk_25mhz (clk_25mhz),
        .reset     (reset),
        .ftdi_rxd  (ftdi_rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    // Handshake and pulse monitor, sampled mid-cycle.
    always @(negedge clk_25mhz) begin
        if (rx_valid) valid_cycles <= valid_cycles + 1;
        if (frame_err) fe_cycles <= fe_cycles + 1;
`ifdef UART_RX_PARITY_EN
        if (parity_err) pe_cycles <= pe_cycles + 1;
`endif
        if (rx_valid && rx_ready) deliv_q.push_back(rx_data);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        ftdi_rxd = v;
        repeat (n) @(posedge clk_25mhz);
        #1;
    endtask

    // One frame: start, 8 data bits LSB first, optional even parity, stop.
    task automatic send_byte(input logic [7:0] b, input logic stop_v, input int stop_len);
        drive(1'b0, BIT);
        for (int i = 0; i < 8; i++) drive(b[i], BIT);
`ifdef UART_RX_PARITY_EN
        drive(^b, BIT);
`endif
        drive(stop_v, stop_len);
        ftdi_rxd = 1'b1;
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_with_parity(input logic [7:0] b, input logic p);
        drive(1'b0, BIT);
        for (int i = 0; i < 8; i++) drive(b[i], BIT);
        drive(p, BIT);
        drive(1'b1, BIT);
    endtask
`endif

    // Wait (bounded) for the expected deliveries, then compare them in order.
    task automatic flush(input string tag);
        int n;
        n = 0;
        while (deliv_q.size() < exp_q.size() && n < 4 * BIT) begin
            @(posedge clk_25mhz);
            n++;
        end
        repeat (20) @(posedge clk_25mhz);
        #1;
        check({tag, " count"}, 32'(deliv_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && deliv_q.size() > 0)
            check({tag, " data"}, 32'(deliv_q.pop_front()), 32'(exp_q.pop_front()));
        deliv_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] a5;
        logic [7:0] b;
        a5 = 8'hA5;

        // Reset values
        repeat (3) @(posedge clk_25mhz);
        @(negedge clk_25mhz);
        check("rst rx_data", 32'(rx_data), 32'h00);
        check("rst rx_valid", 32'(rx_valid), 32'h0);
        check("rst frame_err", 32'(frame_err), 32'h0);
        check("rst overrun", 32'(overrun), 32'h0);
        @(posedge clk_25mhz);
        #1;
        reset = 1'b0;
        drive(1'b1, BIT);

        // Single byte, consumer always ready
        exp_q.push_back(8'h41);
        send_byte(8'h41, 1'b1, BIT);
        flush("byte_41");
        check("valid one cycle", 32'(valid_cycles), 32'd1);
        check("no frame_err 41", 32'(fe_cycles), 32'd0);

        // Back-to-back frames
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_byte(8'h00, 1'b1, BIT);
        send_byte(8'hFF, 1'b1, BIT);
        flush("b2b");
        check("b2b valid cycles", 32'(valid_cycles), 32'd3);

        // Stop bit low at its sample point
        send_byte(8'h55, 1'b0, 150);
        drive(1'b1, 3 * BIT);
        flush("stop_low");
        check("frame_err pulse", 32'(fe_cycles), 32'd1);
        check("stop_low no valid", 32'(valid_cycles), 32'd3);
        check("stop_low no overrun", 32'(overrun), 32'h0);

        // Short low glitch on idle line
        drive(1'b0, 5);
        drive(1'b1, 3 * BIT);
        flush("glitch");
        check("glitch frame_err", 32'(fe_cycles), 32'd1);
        check("glitch rx_valid", 32'(rx_valid), 32'h0);

        // Overrun: consumer stalled across two frames
        rx_ready = 1'b0;
        send_byte(8'h12, 1'b1, BIT);
        send_byte(8'h34, 1'b1, BIT);
        drive(1'b1, BIT);
        check("ovr rx_valid", 32'(rx_valid), 32'h1);
        check("ovr rx_data", 32'(rx_data), 32'h12);
        check("ovr overrun", 32'(overrun), 32'h1);
        rx_ready = 1'b1;
        exp_q.push_back(8'h12);
        flush("ovr drain");
        check("ovr sticky", 32'(overrun), 32'h1);
        check("ovr drained", 32'(rx_valid), 32'h0);

        // Reset during bit 4 of 0xA5, then a clean frame
        drive(1'b0, BIT);
        for (int i = 0; i < 4; i++) drive(a5[i], BIT);
        drive(a5[4], BIT / 2);
        ftdi_rxd = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge clk_25mhz);
        #1;
        check("midrst overrun", 32'(overrun), 32'h0);
        check("midrst rx_valid", 32'(rx_valid), 32'h0);
        reset = 1'b0;
        drive(1'b1, BIT);
        exp_q.push_back(8'h3C);
        send_byte(8'h3C, 1'b1, BIT);
        flush("after_reset");
        check("after_reset frame_err", 32'(fe_cycles), 32'd1);

        // Random bytes with random idle gaps
        for (int k = 0; k < 6; k++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            send_byte(b, 1'b1, BIT);
            drive(1'b1, int'($urandom_range(0, 300)));
        end
        flush("random");
        check("random frame_err", 32'(fe_cycles), 32'd1);
        check("random overrun", 32'(overrun), 32'h0);

`ifdef UART_RX_PARITY_EN
        // 0x07 has three ones: even parity bit is 1
        send_with_parity(8'h07, 1'b0);
        drive(1'b1, BIT);
        flush("parity bad");
        check("parity_err pulse", 32'(pe_cycles), 32'd1);
        exp_q.push_back(8'h07);
        send_with_parity(8'h07, 1'b1);
        flush("parity good");
        check("parity_err quiet", 32'(pe_cycles), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
